// File: rtl/prga_pkg.sv
// prga_pkg
//   Shared definitions for the ARC4 keystream generator with discard.
//   Holds the controller state encoding, the length-source encodings
//   and the fixed byte width and RAM addresses used by prga_drop.
package prga_pkg;

  localparam int BYTE_W = 8;

  // ct[0] carries the message length and pt[0] receives it back.
  localparam logic [BYTE_W-1:0] LEN_ADDR = '0;

  // Length source selection for the LEN_MODE parameter.
  localparam int LEN_MODE_CT   = 0;  // length read from ct[0]
  localparam int LEN_MODE_PORT = 1;  // length sampled from len_in with en

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6
  } state_t;

endpackage

// File: rtl/prga_drop.sv
// prga_drop
//   ARC4 pseudo-random generation stage with RC4-drop[N] keystream
//   discard. Runs after key scheduling, owns the S, CT and PT single-port
//   synchronous RAMs, XORs keystream onto ciphertext and writes plaintext.
//   Every message keystream byte is also strobed out for debug use.
//
//   Parameters
//     DROP      keystream bytes generated and discarded first (0..4095)
//     LEN_MODE  LEN_MODE_CT: length from ct[0]; LEN_MODE_PORT: from len_in
//
//   Ports
//     clk, rst_n             clock, asynchronous active-low reset
//     en, rdy                start request (sampled while rdy=1) / idle
//     len_in                 message length for LEN_MODE_PORT
//     s_addr/s_wrdata/s_wren/s_rddata     S RAM port
//     ct_addr/ct_rddata                   CT RAM read port
//     pt_addr/pt_wrdata/pt_wren/pt_rddata PT RAM port (read data unused)
//     ks_valid, ks_data      one-cycle strobe per message keystream byte
module prga_drop
  import prga_pkg::*;
#(
  parameter int DROP     = 0,
  parameter int LEN_MODE = LEN_MODE_CT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [BYTE_W-1:0] len_in,
  output logic [BYTE_W-1:0] s_addr,
  output logic [BYTE_W-1:0] s_wrdata,
  input  logic [BYTE_W-1:0] s_rddata,
  output logic              s_wren,
  output logic [BYTE_W-1:0] ct_addr,
  input  logic [BYTE_W-1:0] ct_rddata,
  output logic [BYTE_W-1:0] pt_addr,
  output logic [BYTE_W-1:0] pt_wrdata,
  output logic              pt_wren,
  input  logic [BYTE_W-1:0] pt_rddata,
  output logic              ks_valid,
  output logic [BYTE_W-1:0] ks_data
);

  localparam int  DCNT_W   = (DROP < 1) ? 1 : $clog2(DROP + 1);
  localparam bit  LEN_PORT = (LEN_MODE == LEN_MODE_PORT);

  typedef logic [BYTE_W-1:0] byte_t;

  state_t            state;
  state_t            state_nx;

  // Control registers (reset)
  byte_t             i_idx;
  byte_t             j_idx;
  byte_t             k_idx;
  logic [DCNT_W-1:0] drop_cnt;

  // Datapath registers (not reset; always written before use)
  byte_t             si;
  byte_t             sj;
  byte_t             len;
  byte_t             len_hold;

  logic              drop_phase;
  logic [DCNT_W-1:0] drop_cnt_nx;
  byte_t             k_nx;
  byte_t             len_src;
  logic              more_after_len;
  logic              more_after_byte;
  byte_t             pad;

  logic              unused_pt_rd;
  assign unused_pt_rd = ^pt_rddata;

  // Length value presented while in LEN_WR; in port mode the read of
  // ct[0] still happens on the bus but its data is ignored.
  assign len_src = LEN_PORT ? len_hold : ct_rddata;

  assign drop_phase  = (drop_cnt != '0);
  assign drop_cnt_nx = drop_phase ? (drop_cnt - DCNT_W'(1)) : drop_cnt;
  assign k_nx        = drop_phase ? k_idx : (k_idx + byte_t'(1));

  // A run with nothing to drop and zero length ends right after pt[0].
  assign more_after_len  = drop_phase || (len_src != '0);
  // Continue while discard bytes remain or message bytes are outstanding,
  // judged on the values this S6 is about to commit.
  assign more_after_byte = (drop_cnt_nx != '0) || (k_nx < len);

  assign pad = s_rddata;

  // ---- state register and control counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_idx    <= '0;
      j_idx    <= '0;
      k_idx    <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (en) begin
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            drop_cnt <= DCNT_W'(DROP);
          end
        end
        S1: i_idx <= i_idx + byte_t'(1);
        S2: j_idx <= j_idx + s_rddata;
        S6: begin
          drop_cnt <= drop_cnt_nx;
          k_idx    <= k_nx;
        end
        default: ;
      endcase
    end
  end

  // ---- datapath captures ----
  always_ff @(posedge clk) begin
    if (state == IDLE && en) len_hold <= len_in;
    if (state == LEN_WR)     len      <= len_src;
    if (state == S2)         si       <= s_rddata;
    if (state == S3)         sj       <= s_rddata;
  end

  // ---- next state ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = LEN_RD;
      LEN_RD:  state_nx = LEN_WR;
      LEN_WR:  state_nx = more_after_len ? S1 : IDLE;
      S1:      state_nx = S2;
      S2:      state_nx = S3;
      S3:      state_nx = S4;
      S4:      state_nx = S5;
      S5:      state_nx = S6;
      S6:      state_nx = more_after_byte ? S1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- RAM and strobe outputs ----
  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    ks_valid  = 1'b0;
    ks_data   = '0;
    case (state)
      IDLE: rdy = 1'b1;
      LEN_RD: ct_addr = LEN_ADDR;
      LEN_WR: begin
        pt_addr   = LEN_ADDR;
        pt_wrdata = len_src;
        pt_wren   = 1'b1;
      end
      // S[i+1] read; i advances at this edge.
      S1: s_addr = i_idx + byte_t'(1);
      // S[j + S[i]] read using the freshly returned S[i].
      S2: s_addr = j_idx + s_rddata;
      // Swap, first half: S[i] <= S[j].
      S3: begin
        s_addr   = i_idx;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      // Swap, second half: S[j] <= old S[i].
      S4: begin
        s_addr   = j_idx;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      S5: begin
        s_addr  = si + sj;
        ct_addr = k_idx + byte_t'(1);
      end
      S6: begin
        if (!drop_phase) begin
          pt_addr   = k_idx + byte_t'(1);
          pt_wrdata = pad ^ ct_rddata;
          pt_wren   = 1'b1;
          ks_valid  = 1'b1;
          ks_data   = pad;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_drop.sv
// tb_prga_drop
//   Three prga_drop instances (DROP=0/ct length, DROP=1/ct length,
//   DROP=3/port length), each with its own behavioural S/CT/PT RAMs.
//   A plain RC4 reference computes expected keystream, plaintext, final S
//   and busy time; a negedge monitor checks every keystream strobe and the
//   PT write order as they happen.
module tb_prga_drop;

  logic       clk;
  logic       rst_n;
  logic       en        [3];
  logic [7:0] len_in    [3];
  logic       rdy       [3];
  logic [7:0] s_addr    [3];
  logic [7:0] s_wrdata  [3];
  logic [7:0] s_rd      [3];
  logic       s_wren    [3];
  logic [7:0] ct_addr   [3];
  logic [7:0] ct_rd     [3];
  logic [7:0] pt_addr   [3];
  logic [7:0] pt_wrdata [3];
  logic       pt_wren   [3];
  logic [7:0] pt_rd     [3];
  logic       ks_valid  [3];
  logic [7:0] ks_data   [3];

  // RAM contents and bench-side reference state
  logic [7:0] sm     [3][256];
  logic [7:0] ptm    [3][256];
  logic [7:0] ctm    [3][256];
  logic [7:0] s_init [3][256];
  logic [7:0] ms     [3][256];
  logic [7:0] ept    [256];
  logic       ld     [3];
  logic       clr    [3];

  logic [7:0] exp_ks [$];
  int         ks_cnt [3];
  int         wr_cnt [3];
  int         nxt_pt [3];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prga_drop #(
      .DROP    ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .LEN_MODE((g == 2) ? 1 : 0)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .rdy      (rdy[g]),
      .len_in   (len_in[g]),
      .s_addr   (s_addr[g]),
      .s_wrdata (s_wrdata[g]),
      .s_rddata (s_rd[g]),
      .s_wren   (s_wren[g]),
      .ct_addr  (ct_addr[g]),
      .ct_rddata(ct_rd[g]),
      .pt_addr  (pt_addr[g]),
      .pt_wrdata(pt_wrdata[g]),
      .pt_wren  (pt_wren[g]),
      .pt_rddata(pt_rd[g]),
      .ks_valid (ks_valid[g]),
      .ks_data  (ks_data[g])
    );
  end

  function automatic int drop_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic bit port_mode(input int d);
    return d == 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Synchronous-read RAMs; ld/clr let the bench preload S and sentinel PT.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      s_rd[d]  <= sm[d][s_addr[d]];
      ct_rd[d] <= ctm[d][ct_addr[d]];
      pt_rd[d] <= ptm[d][pt_addr[d]];
      if (s_wren[d])  sm[d][s_addr[d]]   <= s_wrdata[d];
      if (pt_wren[d]) ptm[d][pt_addr[d]] <= pt_wrdata[d];
      if (ld[d])  for (int x = 0; x < 256; x++) sm[d][x]  <= s_init[d][x];
      if (clr[d]) for (int x = 0; x < 256; x++) ptm[d][x] <= 8'hA5;
    end
  end

  // Per-cycle monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (rdy[d]) begin
          nxt_pt[d] = 0;
          check("idle_quiet", {29'd0, s_wren[d], pt_wren[d], ks_valid[d]}, 32'd0);
        end
        if (ks_valid[d]) begin
          ks_cnt[d]++;
          if (exp_ks.size() == 0) check("ks_unexpected", exp_ks.size(), 1);
          else check("ks_data", ks_data[d], exp_ks.pop_front());
        end
        if (pt_wren[d]) begin
          check("pt_order", pt_addr[d], nxt_pt[d]);
          nxt_pt[d]++;
          wr_cnt[d]++;
        end
      end
    end
  end

  // Plain RC4-drop reference; advances ms[d] and fills ept / exp_ks.
  task automatic model(input int d, input int L);
    logic [7:0] i, j, t, idx;
    int kk;
    i = 0; j = 0; kk = 0;
    ept[0] = L[7:0];
    for (int n = 0; n < drop_of(d) + L; n++) begin
      i = i + 8'd1;
      j = j + ms[d][i];
      t = ms[d][i]; ms[d][i] = ms[d][j]; ms[d][j] = t;
      idx = ms[d][i] + ms[d][j];
      if (n >= drop_of(d)) begin
        exp_ks.push_back(ms[d][idx]);
        ept[kk+1] = ms[d][idx] ^ ctm[d][kk+1];
        kk++;
      end
    end
  endtask

  task automatic load(input int d, input bit ident);
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) s_init[d][x] = x[7:0];
    if (!ident) begin
      for (int x = 255; x > 0; x--) begin
        r = $urandom_range(x, 0);
        t = s_init[d][x]; s_init[d][x] = s_init[d][r]; s_init[d][r] = t;
      end
    end
    for (int x = 0; x < 256; x++) ms[d][x] = s_init[d][x];
    @(negedge clk); ld[d] = 1'b1;
    @(negedge clk); ld[d] = 1'b0;
  endtask

  task automatic pulse_clr(input int d);
    @(negedge clk); clr[d] = 1'b1;
    @(negedge clk); clr[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [7:0] lin, input bit wiggle, output int busy);
    int L, exp_busy, ks0, wr0, bad;
    L = port_mode(d) ? int'(lin) : int'(ctm[d][0]);
    pulse_clr(d);
    model(d, L);
    exp_busy = 2 + 6 * (drop_of(d) + L);
    ks0 = ks_cnt[d];
    wr0 = wr_cnt[d];
    len_in[d] = lin;
    en[d] = 1'b1;
    @(posedge clk); #1;
    en[d] = 1'b0;
    if (wiggle) len_in[d] = 8'($urandom);
    @(negedge clk);
    busy = 0;
    while (!rdy[d] && busy < 5000) begin
      busy++;
      if (wiggle && busy == 3) en[d] = 1'b1;
      if (wiggle && busy == 4) en[d] = 1'b0;
      @(negedge clk);
    end
    en[d] = 1'b0;
    check($sformatf("busy_d%0d_len%0d", d, L), busy, exp_busy);
    check("ks_count", ks_cnt[d] - ks0, L);
    check("pt_writes", wr_cnt[d] - wr0, L + 1);
    check("ks_leftover", exp_ks.size(), 0);
    exp_ks.delete();
    bad = 0;
    for (int k = 0; k <= L; k++) if (ptm[d][k] !== ept[k]) bad++;
    check("pt_contents_bad", bad, 0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (sm[d][x] !== ms[d][x]) bad++;
    check("s_contents_bad", bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, n, guard, lin;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0; len_in[d] = 8'd0; ld[d] = 1'b0; clr[d] = 1'b0;
      for (int x = 0; x < 256; x++) ctm[d][x] = 8'd0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_rdy", rdy[d], 1);
      check("reset_outs", {s_addr[d], s_wrdata[d], ct_addr[d], pt_addr[d]}, 32'd0);
      check("reset_outs2", {pt_wrdata[d], ks_data[d], 13'd0, s_wren[d], pt_wren[d], ks_valid[d]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Identity S, one byte: keystream 0x02
    load(0, 1'b1);
    ctm[0][0] = 8'd1; ctm[0][1] = 8'h00;
    run(0, 8'd0, 1'b0, busy);
    check("t1_busy", busy, 8);
    check("t1_pt0", ptm[0][0], 8'h01);
    check("t1_pt1", ptm[0][1], 8'h02);

    // Identity S, two bytes: second pad 0x05 -> 0xFA
    load(0, 1'b1);
    ctm[0][0] = 8'd2; ctm[0][1] = 8'h00; ctm[0][2] = 8'hFF;
    run(0, 8'd0, 1'b0, busy);
    check("t2_busy", busy, 14);
    check("t2_pt2", ptm[0][2], 8'hFA);
    check("t2_s2", sm[0][2], 8'd3);
    check("t2_s3", sm[0][3], 8'd2);

    // DROP=1: first pad (0x02) discarded, message sees 0x05
    load(1, 1'b1);
    ctm[1][0] = 8'd1; ctm[1][1] = 8'h00;
    run(1, 8'd0, 1'b0, busy);
    check("t3_busy", busy, 14);
    check("t3_pt1", ptm[1][1], 8'h05);

    // Port length with a misleading ct[0]; len_in and en disturbed while busy
    load(2, 1'b1);
    ctm[2][0] = 8'h50; ctm[2][1] = 8'h11; ctm[2][2] = 8'h22; ctm[2][3] = 8'h33;
    run(2, 8'd3, 1'b1, busy);
    check("t4_busy", busy, 38);
    check("t4_pt0", ptm[2][0], 8'h03);
    check("t4_pt4_untouched", ptm[2][4], 8'hA5);

    // Port length zero: only the discard phase runs
    run(2, 8'd0, 1'b0, busy);
    check("t5_pt0", ptm[2][0], 8'h00);

    // Asynchronous reset during S3 of the second byte
    load(0, 1'b1);
    for (int x = 1; x < 256; x++) ctm[0][x] = 8'($urandom);
    ctm[0][0] = 8'd3;
    pulse_clr(0);
    model(0, 3);
    en[0] = 1'b1;
    @(posedge clk); #1;
    en[0] = 1'b0;
    n = 0; guard = 0;
    while (n < 3 && guard < 200) begin
      @(posedge clk); #1;
      if (s_wren[0]) n++;
      guard++;
    end
    check("rst_reach_s3", n, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy[0], 1);
    check("rst_wren", {s_wren[0], pt_wren[0], ks_valid[0]}, 3'b000);
    check("rst_addr", {s_addr[0], ct_addr[0], pt_addr[0]}, 24'd0);
    @(negedge clk) rst_n = 1'b1;
    exp_ks.delete();
    load(0, 1'b1);
    run(0, 8'd0, 1'b0, busy);
    check("rst_rerun_busy", busy, 20);

    // en held high with zero length: 2 busy, 1 ready, repeating
    load(0, 1'b1);
    ctm[0][0] = 8'd0;
    pulse_clr(0);
    n = wr_cnt[0];
    en[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("hold_rdy_c%0d", c), rdy[0], (c % 3) == 2);
    end
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_pt_writes", wr_cnt[0] - n, 3);
    check("hold_pt0", ptm[0][0], 8'h00);

    // Longest message on the ct-length path
    load(0, 1'b0);
    for (int x = 0; x < 256; x++) ctm[0][x] = 8'($urandom);
    ctm[0][0] = 8'd255;
    run(0, 8'd0, 1'b0, busy);

    // Randomised S, ciphertext and lengths; S carries over between runs
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 2; r++) begin
        load(d, 1'b0);
        for (int x = 0; x < 256; x++) ctm[d][x] = 8'($urandom);
        for (int m = 0; m < 4; m++) begin
          lin = $urandom_range(20, 0);
          if (!port_mode(d)) ctm[d][0] = 8'($urandom_range(20, 0));
          run(d, lin[7:0], m[0], busy);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
